// File: rtl/wb_stage_pipe.sv
// Writeback stage with a one-entry MEM/WB holding slot: waits for late load data,
// formats it by access size and drives a registered register-file write port.
module wb_stage_pipe #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int LINK_OFFSET = 8,
  parameter int MAX_WAIT    = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_memtoreg,
  input  logic                         in_regwrite,
  input  logic [REG_AW-1:0]            in_rd,
  input  logic [DATA_W-1:0]            in_alu,
  input  logic [DATA_W-1:0]            in_pc,
  input  logic [2:0]                   in_ld_type,
  input  logic [$clog2(DATA_W/8)-1:0]  in_byte_off,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_rvalid,
  output logic                         wb_we,
  output logic [REG_AW-1:0]            wb_addr,
  output logic [DATA_W-1:0]            wb_data,
  output logic                         busy,
  output logic                         err_timeout
);

  localparam int OFF_W = $clog2(DATA_W/8);
  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  waitCnt;
  logic [1:0]        slotSrc;
  logic              slotRegWrite;
  logic [REG_AW-1:0] slotRd;
  logic [DATA_W-1:0] slotAlu;
  logic [DATA_W-1:0] slotPc;
  logic [2:0]        slotLdType;
  logic [OFF_W-1:0]  slotByteOff;

  logic              inWait;
  logic              accept;
  logic              complete;
  logic              timeoutHit;
  logic [OFF_W-1:0]  halfOff;
  logic [OFF_W-1:0]  wordOff;
  logic [7:0]        byteLane;
  logic [15:0]       halfLane;
  logic [31:0]       wordLane;
  logic [DATA_W-1:0] loadVal;
  logic [DATA_W-1:0] selData;

  assign inWait   = (state == S_WAIT);
  assign busy     = inWait;
  assign in_ready = !inWait || mem_rvalid;
  assign accept   = in_valid && in_ready && !flush;
  assign complete = !flush && ((state == S_EXEC) || (inWait && mem_rvalid));
  // A flush in the last wait cycle wins over the timeout, so no error is reported.
  assign timeoutHit = (MAX_WAIT != 0) && inWait && !mem_rvalid && !flush
                      && (waitCnt == WAIT_LAST);

  always_comb begin
    halfOff  = slotByteOff & ~OFF_W'(1);
    wordOff  = slotByteOff & ~OFF_W'(3);
    byteLane = 8'(mem_rdata >> {slotByteOff, 3'b000});
    halfLane = 16'(mem_rdata >> {halfOff, 3'b000});
    wordLane = 32'(mem_rdata >> {wordOff, 3'b000});
    loadVal  = mem_rdata;
    case (slotLdType)
      3'b000:  loadVal = DATA_W'($signed(byteLane));
      3'b001:  loadVal = DATA_W'($signed(halfLane));
      3'b010:  loadVal = DATA_W'($signed(wordLane));
      3'b100:  loadVal = DATA_W'(byteLane);
      3'b101:  loadVal = DATA_W'(halfLane);
      3'b110:  loadVal = (DATA_W == 32) ? mem_rdata : DATA_W'(wordLane);
      default: loadVal = mem_rdata;
    endcase
  end

  always_comb begin
    case (slotSrc)
      2'd0:    selData = slotAlu;
      2'd1:    selData = loadVal;
      2'd2:    selData = slotPc + DATA_W'(LINK_OFFSET);
      default: selData = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      waitCnt      <= '0;
      slotSrc      <= '0;
      slotRegWrite <= 1'b0;
      slotRd       <= '0;
      slotAlu      <= '0;
      slotPc       <= '0;
      slotLdType   <= '0;
      slotByteOff  <= '0;
      wb_we        <= 1'b0;
      wb_addr      <= '0;
      wb_data      <= '0;
      err_timeout  <= 1'b0;
    end else begin
      err_timeout <= timeoutHit;

      if (accept) begin
        state        <= (in_memtoreg == 2'd1) ? S_WAIT : S_EXEC;
        slotSrc      <= in_memtoreg;
        slotRegWrite <= in_regwrite;
        slotRd       <= in_rd;
        slotAlu      <= in_alu;
        slotPc       <= in_pc;
        slotLdType   <= in_ld_type;
        slotByteOff  <= in_byte_off;
      end else if (inWait && !mem_rvalid && !flush && !timeoutHit) begin
        state <= S_WAIT;
      end else begin
        state <= S_IDLE;
      end

      if (accept && (in_memtoreg == 2'd1)) begin
        waitCnt <= '0;
      end else if (inWait && !mem_rvalid) begin
        waitCnt <= waitCnt + CNT_W'(1);
      end

      if (complete) begin
        wb_we   <= slotRegWrite && (slotRd != '0) && (slotSrc != 2'd3);
        wb_addr <= slotRd;
        wb_data <= selData;
      end else begin
        wb_we <= 1'b0;
      end
    end
  end

endmodule

// File: doc/wb_stage_pipe.md
# wb_stage_pipe

Parametrised writeback stage with an integrated MEM/WB holding slot. It accepts one retiring instruction per cycle over a valid/ready handshake and waits for late memory read data. It formats load data by access size, selects the writeback source (ALU, memory or link PC) and drives a registered register-file write port. It sits between the memory stage and the register file and replaces the purely combinational writeback mux.

## Interface
- DATA_W, 32, datapath width; 32 or 64
- REG_AW, 5, register address width
- LINK_OFFSET, 8, added to `in_pc` for the link source
- MAX_WAIT, 15, maximum number of cycles spent waiting for memory data; 0 disables the timeout
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  discard the held instruction and any capture this cycle
- in_valid  in  1  the upstream stage presents an instruction
- in_ready  out  1  the stage can accept an instruction this cycle
- in_memtoreg  in  2  writeback source: 0 ALU, 1 memory, 2 link, 3 none
- in_regwrite  in  1  the instruction writes a register
- in_rd  in  REG_AW  destination register
- in_alu  in  DATA_W  ALU result
- in_pc  in  DATA_W  PC of the instruction
- in_ld_type  in  3  000 LB, 001 LH, 010 LW, 011 LD (full width, 64-bit only), 100 LBU, 101 LHU, 110 LWU (64-bit only)
- in_byte_off  in  log2(DATA_W/8)  byte offset of the load address
- mem_rdata  in  DATA_W  memory read data, full aligned word
- mem_rvalid  in  1  `mem_rdata` is valid this cycle
- wb_we  out  1  register-file write enable
- wb_addr  out  REG_AW  register-file write address
- wb_data  out  DATA_W  register-file write data
- busy  out  1  the stage is waiting for memory data
- err_timeout  out  1  one-cycle pulse when a load is dropped on timeout

## Operation
- States:
  - IDLE: slot empty.
  - EXEC: slot holds a non-memory instruction.
  - WAIT: slot holds a memory-source instruction.
- Accept condition: `in_valid && in_ready && !flush`.
  - Capture source 1 into WAIT; capture any other source into EXEC.
  - With no acceptance, go to IDLE.
- The EXEC slot always completes in its first cycle.
- The WAIT slot completes in the cycle `mem_rvalid` = 1. It then recaptures or goes to IDLE per the accept condition.
- `in_ready` = (state != WAIT) || mem_rvalid. The handshake is combinational; `flush` does not gate `in_ready`.
- `mem_rvalid` is ignored outside WAIT.
- Completion registers the write port at the next edge:
  - wb_we = regwrite && rd != 0 && src != 3.
  - wb_addr = rd.
  - wb_data = the selected value, or 0 when src = 3.
- With no completion, wb_we = 0 and wb_addr/wb_data hold their previous values.
- Source values:
  - ALU: in_alu.
  - Link: in_pc + LINK_OFFSET, modulo 2^DATA_W.
  - Memory: formatted mem_rdata.
- Load formatting:
  - Byte lane = byte_off.
  - Half lane = byte_off >> 1; word lane = byte_off >> 2. The low address bits below the access size are ignored.
  - LB, LH, LW sign-extend to DATA_W. LBU, LHU, LWU zero-extend.
  - LD takes the full word.
  - On DATA_W = 32, LW takes the full word; 011 and 110 behave as LW.
- Timeout:
  - The wait counter clears on entry to WAIT.
  - It increments each WAIT cycle without `mem_rvalid`.
  - When the counter reaches MAX_WAIT:
    - the instruction is dropped (no write);
    - err_timeout pulses for one cycle;
    - the state goes to IDLE and `in_ready` = 1 in the following cycle.
- Flush: the slot is discarded with no write, no err_timeout, and no capture this cycle; the state goes to IDLE.
  - A completion that `mem_rvalid` would trigger in the same cycle is also suppressed.
  - A write already registered on wb_* is not retracted.

## Timing
- Reset values:
  - state IDLE;
  - wb_we 0, wb_addr 0, wb_data 0;
  - busy 0, err_timeout 0;
  - wait counter 0;
  - `in_ready` 1.
- Reset is asynchronous and takes effect mid-wait. The pending load is lost with no write.
- Non-memory latency: accepted at edge N, wb_we = 1 during the cycle after edge N+1, for one cycle.
- Load latency: wb_we = 1 during the cycle after the edge that samples `mem_rvalid` = 1.
- Back-to-back non-memory instructions produce one write per cycle.
- busy = (state == WAIT), registered.

## Test plan
- ALU op: in_alu = 0x1234, rd = 3, regwrite = 1, src = 0 -> one cycle later wb_we = 1, wb_addr = 3, wb_data = 0x00001234. With rd = 0 -> wb_we = 0.
- Link: in_pc = 0x00400010, src = 2 -> wb_data = 0x00400018.
- Byte loads: mem_rdata = 0x80FF7F01 with rvalid 3 cycles late; busy = 1 and in_ready = 0 meanwhile.
  - LB, off 3 -> 0xFFFFFF80.
  - LBU, off 3 -> 0x00000080.
  - LH, off 2 -> 0xFFFF80FF.
  - LW -> 0x80FF7F01.
- Back-to-back: ALU, load, ALU, with rvalid in the load's first WAIT cycle -> three writes on consecutive cycles, in order.
- Timeout, MAX_WAIT = 4, no rvalid -> err_timeout pulses once after 4 WAIT cycles, no write, then in_ready = 1.
- Flush and reset:
  - flush in the rvalid cycle -> no write; a concurrent in_valid is not captured.
  - rst_n low mid-WAIT -> all outputs return to reset values immediately.
